// File: rtl/mem2_stage.sv
// MEM2 stage of the dual-issue pipeline: waits for lane 0's data-SRAM load response,
// aligns/extends it, and hands both lanes to WB. Stale responses of flushed loads are absorbed.
module mem2_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m1s_to_m2s_valid,
    input  logic [31:0] m1s_pc_0,
    input  logic [31:0] m1s_pc_1,
    input  logic [4:0]  m1s_rd_0,
    input  logic [4:0]  m1s_rd_1,
    input  logic        m1s_reg_write_0,
    input  logic        m1s_reg_write_1,
    input  logic [31:0] m1s_result_0,
    input  logic [31:0] m1s_result_1,
    input  logic        m1s_mem_req_0,
    input  logic [2:0]  m1s_load_type_0,
    input  logic [1:0]  m1s_addr_lo_0,
    output logic        m2s_allowin,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wbs_allowin,
    input  logic        m2s_flush,
    output logic [1:0]  m2s_to_wbs_valid,
    output logic [31:0] m2s_pc_0,
    output logic [31:0] m2s_pc_1,
    output logic [4:0]  m2s_rd_0,
    output logic [4:0]  m2s_rd_1,
    output logic        m2s_reg_write_0,
    output logic        m2s_reg_write_1,
    output logic [31:0] m2s_wdata_0,
    output logic [31:0] m2s_wdata_1,
    output logic        m2s_mem_wait
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HAVE,
        S_DROP
    } load_state_t;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic [1:0]  valid_r;
    logic [31:0] pc_0_r, pc_1_r;
    logic [4:0]  rd_0_r, rd_1_r;
    logic        reg_write_0_r, reg_write_1_r;
    logic [31:0] result_0_r, result_1_r;
    logic        mem_req_0_r;
    logic [2:0]  load_type_0_r;
    logic [1:0]  addr_lo_0_r;
    logic [31:0] rdata_buf;

    load_state_t state, state_nxt;

    logic        valid_any;
    logic        resp_now;
    logic        ready_go;
    logic        pair_leaving;
    logic        capture_load;
    logic        buf_load;
    logic [31:0] load_src;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign valid_any    = |valid_r;
    assign resp_now     = (state == S_WAIT) && data_sram_data_ok;
    assign ready_go     = !valid_any || !mem_req_0_r || (state == S_HAVE) || resp_now;
    assign m2s_allowin  = (state != S_DROP) && (!valid_any || (ready_go && wbs_allowin));
    assign pair_leaving = valid_any && ready_go && wbs_allowin;
    assign capture_load = m2s_allowin && m1s_to_m2s_valid[0] && m1s_mem_req_0;
    assign buf_load     = resp_now && !m2s_flush && !pair_leaving;

    // NOTE: next-state starts from a default so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (capture_load) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    if (m2s_flush || pair_leaving)
                        state_nxt = capture_load ? S_WAIT : S_IDLE;
                    else
                        state_nxt = S_HAVE;
                end else if (m2s_flush) begin
                    state_nxt = S_DROP;
                end
            end
            S_HAVE: begin
                if (m2s_flush || pair_leaving)
                    state_nxt = capture_load ? S_WAIT : S_IDLE;
            end
            S_DROP: begin
                if (data_sram_data_ok) state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nxt;
            if (buf_load) rdata_buf <= data_sram_rdata;
        end
    end

    // Lane fields are zeroed for invalid lanes so nothing stale leaks into forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r       <= '0;
            pc_0_r        <= '0;
            pc_1_r        <= '0;
            rd_0_r        <= '0;
            rd_1_r        <= '0;
            reg_write_0_r <= 1'b0;
            reg_write_1_r <= 1'b0;
            result_0_r    <= '0;
            result_1_r    <= '0;
            mem_req_0_r   <= 1'b0;
            load_type_0_r <= '0;
            addr_lo_0_r   <= '0;
        end else if (m2s_allowin) begin
            valid_r       <= m1s_to_m2s_valid;
            pc_0_r        <= m1s_to_m2s_valid[0] ? m1s_pc_0        : '0;
            rd_0_r        <= m1s_to_m2s_valid[0] ? m1s_rd_0        : '0;
            reg_write_0_r <= m1s_to_m2s_valid[0] && m1s_reg_write_0;
            result_0_r    <= m1s_to_m2s_valid[0] ? m1s_result_0    : '0;
            mem_req_0_r   <= m1s_to_m2s_valid[0] && m1s_mem_req_0;
            load_type_0_r <= m1s_to_m2s_valid[0] ? m1s_load_type_0 : '0;
            addr_lo_0_r   <= m1s_to_m2s_valid[0] ? m1s_addr_lo_0   : '0;
            pc_1_r        <= m1s_to_m2s_valid[1] ? m1s_pc_1        : '0;
            rd_1_r        <= m1s_to_m2s_valid[1] ? m1s_rd_1        : '0;
            reg_write_1_r <= m1s_to_m2s_valid[1] && m1s_reg_write_1;
            result_1_r    <= m1s_to_m2s_valid[1] ? m1s_result_1    : '0;
        end else if (m2s_flush) begin
            valid_r <= '0;
        end
    end

    // Response data bypasses the buffer in the cycle it arrives.
    assign load_src  = resp_now ? data_sram_rdata : rdata_buf;
    assign load_half = addr_lo_0_r[1] ? load_src[31:16] : load_src[15:0];

    always_comb begin
        load_byte = load_src[7:0];
        case (addr_lo_0_r)
            2'd0: load_byte = load_src[7:0];
            2'd1: load_byte = load_src[15:8];
            2'd2: load_byte = load_src[23:16];
            2'd3: load_byte = load_src[31:24];
        endcase
    end

    always_comb begin
        load_data = load_src;
        case (load_type_0_r)
            LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_data = {24'b0, load_byte};
            LT_LH:   load_data = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_data = {16'b0, load_half};
            default: load_data = load_src;
        endcase
    end

    assign m2s_to_wbs_valid = valid_r & {2{ready_go && !m2s_flush}};
    assign m2s_pc_0         = pc_0_r;
    assign m2s_pc_1         = pc_1_r;
    assign m2s_rd_0         = rd_0_r;
    assign m2s_rd_1         = rd_1_r;
    assign m2s_reg_write_0  = reg_write_0_r && valid_r[0];
    assign m2s_reg_write_1  = reg_write_1_r && valid_r[1];
    assign m2s_wdata_0      = mem_req_0_r ? load_data : result_0_r;
    assign m2s_wdata_1      = result_1_r;
    assign m2s_mem_wait     = valid_r[0] && mem_req_0_r && (state == S_WAIT) && !data_sram_data_ok;

endmodule

// File: tb/tb_mem2_stage.sv
// Bench for mem2_stage: load-extraction table, directed multi-cycle sequences,
// and a randomized run against a slot/outstanding-response reference model.
module tb_mem2_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  m1s_to_m2s_valid;
    logic [31:0] m1s_pc_0, m1s_pc_1;
    logic [4:0]  m1s_rd_0, m1s_rd_1;
    logic        m1s_reg_write_0, m1s_reg_write_1;
    logic [31:0] m1s_result_0, m1s_result_1;
    logic        m1s_mem_req_0;
    logic [2:0]  m1s_load_type_0;
    logic [1:0]  m1s_addr_lo_0;
    logic        m2s_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wbs_allowin;
    logic        m2s_flush;
    logic [1:0]  m2s_to_wbs_valid;
    logic [31:0] m2s_pc_0, m2s_pc_1;
    logic [4:0]  m2s_rd_0, m2s_rd_1;
    logic        m2s_reg_write_0, m2s_reg_write_1;
    logic [31:0] m2s_wdata_0, m2s_wdata_1;
    logic        m2s_mem_wait;

    mem2_stage dut (
        .clk               (clk),
        .reset             (reset),
        .m1s_to_m2s_valid  (m1s_to_m2s_valid),
        .m1s_pc_0          (m1s_pc_0),
        .m1s_pc_1          (m1s_pc_1),
        .m1s_rd_0          (m1s_rd_0),
        .m1s_rd_1          (m1s_rd_1),
        .m1s_reg_write_0   (m1s_reg_write_0),
        .m1s_reg_write_1   (m1s_reg_write_1),
        .m1s_result_0      (m1s_result_0),
        .m1s_result_1      (m1s_result_1),
        .m1s_mem_req_0     (m1s_mem_req_0),
        .m1s_load_type_0   (m1s_load_type_0),
        .m1s_addr_lo_0     (m1s_addr_lo_0),
        .m2s_allowin       (m2s_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wbs_allowin       (wbs_allowin),
        .m2s_flush         (m2s_flush),
        .m2s_to_wbs_valid  (m2s_to_wbs_valid),
        .m2s_pc_0          (m2s_pc_0),
        .m2s_pc_1          (m2s_pc_1),
        .m2s_rd_0          (m2s_rd_0),
        .m2s_rd_1          (m2s_rd_1),
        .m2s_reg_write_0   (m2s_reg_write_0),
        .m2s_reg_write_1   (m2s_reg_write_1),
        .m2s_wdata_0       (m2s_wdata_0),
        .m2s_wdata_1       (m2s_wdata_1),
        .m2s_mem_wait      (m2s_mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ltype;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ext_vec_t;

    localparam int N_EXT = 13;
    localparam logic [31:0] RD_WORD = 32'h80AA_55CC;

    ext_vec_t vecs [N_EXT];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: one pipeline slot plus a count of responses owed to flushed loads.
    logic [1:0]  s_valid;
    logic [31:0] s_pc0, s_pc1, s_res0, s_res1, s_data;
    logic [4:0]  s_rd0, s_rd1;
    bit          s_we0, s_we1, s_load, s_got;
    logic [2:0]  s_type;
    logic [1:0]  s_addr;
    int          stale, new_stale;
    bit          outstanding, resp_slot, avail, exp_allowin, exp_wait;
    logic [1:0]  exp_valid;
    logic [31:0] exp_wdata0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [1:0] v, input logic req, input logic [2:0] lt,
                              input logic [1:0] al, input logic [31:0] r0, input logic [31:0] r1);
        m1s_to_m2s_valid = v;
        m1s_pc_0         = 32'hBFC0_0100;
        m1s_pc_1         = 32'hBFC0_0104;
        m1s_rd_0         = 5'd8;
        m1s_rd_1         = 5'd9;
        m1s_reg_write_0  = 1'b1;
        m1s_reg_write_1  = 1'b1;
        m1s_result_0     = r0;
        m1s_result_1     = r1;
        m1s_mem_req_0    = req;
        m1s_load_type_0  = lt;
        m1s_addr_lo_0    = al;
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] t, input logic [1:0] a,
                                                input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(a))) & 32'd255;
        h = (w >> (16 * (int'(a) / 2))) & 32'd65535;
        case (t)
            3'd1:    return (b >= 128)   ? b - 32'd256   : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'd1, 2'd0, RD_WORD, 32'hFFFF_FFCC};
        vecs[1]  = '{3'd1, 2'd1, RD_WORD, 32'h0000_0055};
        vecs[2]  = '{3'd1, 2'd2, RD_WORD, 32'hFFFF_FFAA};
        vecs[3]  = '{3'd1, 2'd3, RD_WORD, 32'hFFFF_FF80};
        vecs[4]  = '{3'd2, 2'd0, RD_WORD, 32'h0000_00CC};
        vecs[5]  = '{3'd2, 2'd3, RD_WORD, 32'h0000_0080};
        vecs[6]  = '{3'd3, 2'd0, RD_WORD, 32'h0000_55CC};
        vecs[7]  = '{3'd3, 2'd2, RD_WORD, 32'hFFFF_80AA};
        vecs[8]  = '{3'd3, 2'd3, RD_WORD, 32'hFFFF_80AA};
        vecs[9]  = '{3'd4, 2'd2, RD_WORD, 32'h0000_80AA};
        vecs[10] = '{3'd4, 2'd0, RD_WORD, 32'h0000_55CC};
        vecs[11] = '{3'd0, 2'd1, RD_WORD, 32'h80AA_55CC};
        vecs[12] = '{3'd7, 2'd0, RD_WORD, 32'h80AA_55CC};

        reset             = 1'b1;
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        wbs_allowin       = 1'b1;
        m2s_flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid",    32'(m2s_to_wbs_valid), 32'h0);
        check("reset allowin",  32'(m2s_allowin),      32'h1);
        check("reset mem_wait", 32'(m2s_mem_wait),     32'h0);
        check("reset wdata0",   m2s_wdata_0,           32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single-cycle loads, data_ok in the first MEM2 cycle.
        for (int i = 0; i < N_EXT; i++) begin
            drive_pair(2'b01, 1'b1, vecs[i].ltype, vecs[i].addr, 32'h1111_1111, 32'h0);
            tick();
            drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = vecs[i].rdata;
            #1;
            check($sformatf("ext[%0d] valid", i), 32'(m2s_to_wbs_valid), 32'h1);
            check($sformatf("ext[%0d] wdata", i), m2s_wdata_0,           vecs[i].exp);
            check($sformatf("ext[%0d] allowin", i), 32'(m2s_allowin),    32'h1);
            tick();
            data_sram_data_ok = 1'b0;
        end

        // LHU with three stall cycles.
        drive_pair(2'b01, 1'b1, 3'd4, 2'd2, 32'h0, 32'h0);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lhu wait[%0d] mem_wait", k), 32'(m2s_mem_wait),     32'h1);
            check($sformatf("lhu wait[%0d] allowin", k),  32'(m2s_allowin),      32'h0);
            check($sformatf("lhu wait[%0d] valid", k),    32'(m2s_to_wbs_valid), 32'h0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = RD_WORD;
        #1;
        check("lhu done valid", 32'(m2s_to_wbs_valid), 32'h1);
        check("lhu done wdata", m2s_wdata_0,           32'h0000_80AA);
        tick();
        data_sram_data_ok = 1'b0;

        // LW response held while WB stalls; rdata turns to garbage afterwards.
        drive_pair(2'b01, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = RD_WORD;
        wbs_allowin       = 1'b0;
        #1;
        check("hold first allowin", 32'(m2s_allowin), 32'h0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold[%0d] wdata", k),    m2s_wdata_0,       32'h80AA_55CC);
            check($sformatf("hold[%0d] mem_wait", k), 32'(m2s_mem_wait), 32'h0);
            check($sformatf("hold[%0d] allowin", k),  32'(m2s_allowin),  32'h0);
            tick();
        end
        wbs_allowin = 1'b1;
        #1;
        check("hold issue valid",   32'(m2s_to_wbs_valid), 32'h1);
        check("hold issue wdata",   m2s_wdata_0,           32'h80AA_55CC);
        check("hold issue allowin", 32'(m2s_allowin),      32'h1);
        tick();
        check("hold after valid", 32'(m2s_to_wbs_valid), 32'h0);

        // Flush of an outstanding LW; the stale response must be swallowed.
        drive_pair(2'b01, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        m2s_flush = 1'b1;
        #1;
        check("flush cycle valid", 32'(m2s_to_wbs_valid), 32'h0);
        tick();
        m2s_flush = 1'b0;
        drive_pair(2'b01, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'h0);
        #1;
        check("drop allowin", 32'(m2s_allowin),      32'h0);
        check("drop valid",   32'(m2s_to_wbs_valid), 32'h0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        check("drop ok allowin", 32'(m2s_allowin),      32'h0);
        check("drop ok valid",   32'(m2s_to_wbs_valid), 32'h0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        check("post drop allowin", 32'(m2s_allowin), 32'h1);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        check("post drop valid", 32'(m2s_to_wbs_valid), 32'h1);
        check("post drop wdata", m2s_wdata_0,           32'h0000_1234);
        check("post drop we0",   32'(m2s_reg_write_0),  32'h1);
        tick();

        // Dual non-load pair.
        drive_pair(2'b11, 1'b0, 3'd0, 2'd0, 32'hA5A5_0001, 32'h5A5A_0002);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        check("dual valid",  32'(m2s_to_wbs_valid), 32'h3);
        check("dual wdata0", m2s_wdata_0,           32'hA5A5_0001);
        check("dual wdata1", m2s_wdata_1,           32'h5A5A_0002);
        check("dual pc1",    m2s_pc_1,              32'hBFC0_0104);
        check("dual rd1",    32'(m2s_rd_1),         32'd9);
        check("dual we1",    32'(m2s_reg_write_1),  32'h1);
        tick();

        // Asynchronous reset while a load waits.
        drive_pair(2'b01, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        check("pre reset mem_wait", 32'(m2s_mem_wait), 32'h1);
        reset = 1'b1;
        #1;
        check("async reset valid",    32'(m2s_to_wbs_valid), 32'h0);
        check("async reset allowin",  32'(m2s_allowin),      32'h1);
        check("async reset mem_wait", 32'(m2s_mem_wait),     32'h0);
        check("async reset pc0",      m2s_pc_0,              32'h0);
        #1;
        reset = 1'b0;
        tick();
        drive_pair(2'b01, 1'b0, 3'd0, 2'd0, 32'h0000_0077, 32'h0);
        tick();
        drive_pair(2'b00, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        check("after reset valid", 32'(m2s_to_wbs_valid), 32'h1);
        check("after reset wdata", m2s_wdata_0,           32'h0000_0077);
        tick();

        // Randomized traffic against the reference model.
        s_valid = '0; s_load = 0; s_got = 0; stale = 0;
        s_pc0 = '0; s_pc1 = '0; s_res0 = '0; s_res1 = '0; s_data = '0;
        s_rd0 = '0; s_rd1 = '0; s_we0 = 0; s_we1 = 0; s_type = '0; s_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            outstanding       = (stale > 0) || (s_load && !s_got);
            data_sram_data_ok = outstanding && ($urandom_range(0, 2) != 0);
            data_sram_rdata   = $urandom;
            wbs_allowin       = ($urandom_range(0, 3) != 0);
            m2s_flush         = ($urandom_range(0, 15) == 0);
            m1s_to_m2s_valid  = m2s_flush ? 2'b00 : 2'($urandom_range(0, 3));
            m1s_mem_req_0     = m1s_to_m2s_valid[0] && ($urandom_range(0, 1) == 1);
            m1s_pc_0          = $urandom;
            m1s_pc_1          = $urandom;
            m1s_rd_0          = 5'($urandom);
            m1s_rd_1          = 5'($urandom);
            m1s_reg_write_0   = 1'($urandom);
            m1s_reg_write_1   = 1'($urandom);
            m1s_result_0      = $urandom;
            m1s_result_1      = $urandom;
            m1s_load_type_0   = 3'($urandom_range(0, 7));
            m1s_addr_lo_0     = 2'($urandom);
            #1;

            resp_slot   = data_sram_data_ok && (stale == 0) && s_load && !s_got;
            avail       = !s_load || s_got || resp_slot;
            exp_allowin = (stale == 0) && ((s_valid == 2'b00) || (avail && wbs_allowin));
            exp_valid   = (avail && !m2s_flush) ? s_valid : 2'b00;
            exp_wait    = s_load && !s_got && !data_sram_data_ok;
            exp_wdata0  = s_load ? ref_extract(s_type, s_addr, s_got ? s_data : data_sram_rdata)
                                 : s_res0;

            check("rnd allowin",  32'(m2s_allowin),      32'(exp_allowin));
            check("rnd valid",    32'(m2s_to_wbs_valid), 32'(exp_valid));
            check("rnd mem_wait", 32'(m2s_mem_wait),     32'(exp_wait));
            if (exp_valid[0]) begin
                check("rnd wdata0", m2s_wdata_0,          exp_wdata0);
                check("rnd pc0",    m2s_pc_0,             s_pc0);
                check("rnd rd0",    32'(m2s_rd_0),        32'(s_rd0));
                check("rnd we0",    32'(m2s_reg_write_0), 32'(s_we0));
            end
            if (exp_valid[1]) begin
                check("rnd wdata1", m2s_wdata_1,          s_res1);
                check("rnd pc1",    m2s_pc_1,             s_pc1);
                check("rnd rd1",    32'(m2s_rd_1),        32'(s_rd1));
                check("rnd we1",    32'(m2s_reg_write_1), 32'(s_we1));
            end

            new_stale = stale;
            if (data_sram_data_ok && stale > 0) new_stale = 0;
            if (m2s_flush && s_load && !s_got && !data_sram_data_ok) new_stale = 1;
            if (resp_slot) begin
                s_got  = 1;
                s_data = data_sram_rdata;
            end
            if (exp_allowin) begin
                s_valid = m1s_to_m2s_valid;
                s_pc0   = m1s_to_m2s_valid[0] ? m1s_pc_0     : '0;
                s_rd0   = m1s_to_m2s_valid[0] ? m1s_rd_0     : '0;
                s_res0  = m1s_to_m2s_valid[0] ? m1s_result_0 : '0;
                s_we0   = m1s_to_m2s_valid[0] && m1s_reg_write_0;
                s_pc1   = m1s_to_m2s_valid[1] ? m1s_pc_1     : '0;
                s_rd1   = m1s_to_m2s_valid[1] ? m1s_rd_1     : '0;
                s_res1  = m1s_to_m2s_valid[1] ? m1s_result_1 : '0;
                s_we1   = m1s_to_m2s_valid[1] && m1s_reg_write_1;
                s_load  = m1s_to_m2s_valid[0] && m1s_mem_req_0;
                s_type  = m1s_load_type_0;
                s_addr  = m1s_addr_lo_0;
                s_got   = 0;
            end else if (m2s_flush) begin
                s_valid = 2'b00;
                s_load  = 0;
                s_got   = 0;
            end
            stale = new_stale;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
